// File: rtl/ycbcr_pkg.sv
// Shared constants for the BT.601 full-range colour-space converters (rgb2ycbcr / ycbcr2rgb).
// Q.12 inverse-conversion coefficients, chroma offset, pipeline latency and the strobe bundle type.
package ycbcr_pkg;

    localparam int FRAC_BITS    = 12;
    localparam int K_CR_R       = 5743;
    localparam int K_CB_G       = 1410;
    localparam int K_CR_G       = 2925;
    localparam int K_CB_B       = 7258;
    localparam int CHROMA_OFS   = 128;
    localparam int CONV_LATENCY = 4;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic de;
    } strobe_t;

endpackage

// File: rtl/ycbcr2rgb_if.sv
// Pixel/strobe bundle between the segmentation stage and ycbcr2rgb, plus the converted output side.
// master drives the YCbCr side and observes RGB; slave is the converter.
interface ycbcr2rgb_if;

    logic       ce;
    logic [7:0] Y;
    logic [7:0] Cb;
    logic [7:0] Cr;
    logic       in_hsync;
    logic       in_vsync;
    logic       in_de;
    logic [7:0] R;
    logic [7:0] G;
    logic [7:0] B;
    logic       out_hsync;
    logic       out_vsync;
    logic       out_de;

    modport master (
        output ce, Y, Cb, Cr, in_hsync, in_vsync, in_de,
        input  R, G, B, out_hsync, out_vsync, out_de
    );

    modport slave (
        input  ce, Y, Cb, Cr, in_hsync, in_vsync, in_de,
        output R, G, B, out_hsync, out_vsync, out_de
    );

endinterface

// File: rtl/ycbcr2rgb_sync_delay.sv
// sync_delay: DEPTH x WIDTH shift register with clock enable and async active-low reset.
// Used to keep the HDMI timing strobes aligned with the arithmetic pipeline.
module sync_delay #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_ce,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_sr [DEPTH];

    // NOTE: every stage is reset because a mid-frame reset must drop stale strobes; this is a
    // register chain, not a RAM, so resetting the whole array costs no memory macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_sr[i] <= '0;
        end else if (i_ce) begin
            r_sr[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
        end
    end

    assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/ycbcr2rgb.sv
// ycbcr2rgb: 4-stage BT.601 full-range YCbCr -> RGB converter with ce stall and delayed strobes.
// Build option: define YCBCR2RGB_ROUND_EN for round-half-up, otherwise results are truncated.
module ycbcr2rgb #(
    parameter int FRAC_BITS = ycbcr_pkg::FRAC_BITS
) (
    input logic          clk,
    input logic          rst_n,
    ycbcr2rgb_if.slave   pix
);

    import ycbcr_pkg::*;

    localparam int YW = 8 + FRAC_BITS;   // Y << FRAC_BITS, unsigned
    localparam int PW = 21;              // signed product width
    localparam int SW = 23;              // signed sum width, covers -929024..1973504

    localparam logic signed [PW-1:0] C_CR_R = PW'(K_CR_R);
    localparam logic signed [PW-1:0] C_CB_G = PW'(K_CB_G);
    localparam logic signed [PW-1:0] C_CR_G = PW'(K_CR_G);
    localparam logic signed [PW-1:0] C_CB_B = PW'(K_CB_B);

`ifdef YCBCR2RGB_ROUND_EN
    localparam logic signed [SW-1:0] C_RND = SW'(1) <<< (FRAC_BITS - 1);
`else
    localparam logic signed [SW-1:0] C_RND = '0;
`endif

    // Stage 1: input pixel with chroma offset removed
    logic        [7:0]    r_y1;
    logic signed [8:0]    r_cb1, r_cr1;
    // Stage 2: products and scaled luma
    logic        [YW-1:0] r_y2;
    logic signed [PW-1:0] r_p_cr_r, r_p_cb_g, r_p_cr_g, r_p_cb_b;
    // Stage 3: channel sums
    logic signed [SW-1:0] r_sum_r, r_sum_g, r_sum_b;
    // Stage 4: saturated outputs
    logic        [7:0]    r_r, r_g, r_b;

    logic signed [8:0]    w_cb_s, w_cr_s;
    logic signed [SW-1:0] w_y_x;
    strobe_t              w_strobe_in, w_strobe_out;

    assign w_cb_s = signed'({1'b0, pix.Cb} - 9'(CHROMA_OFS));
    assign w_cr_s = signed'({1'b0, pix.Cr} - 9'(CHROMA_OFS));
    assign w_y_x  = signed'(SW'(r_y2));

    // Drop the fraction with an arithmetic shift and clamp into 0..255.
    function automatic logic [7:0] sat_u8(input logic signed [SW-1:0] sum);
        logic [SW-FRAC_BITS-1:0] q;
        q = sum[SW-1:FRAC_BITS];
        if (q[SW-FRAC_BITS-1])      return 8'd0;
        else if (|q[SW-FRAC_BITS-2:8]) return 8'hFF;
        else                         return q[7:0];
    endfunction

    // NOTE: pipeline state uses non-blocking assignments so each stage reads the previous
    // stage's value from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y1     <= '0;
            r_cb1    <= '0;
            r_cr1    <= '0;
            r_y2     <= '0;
            r_p_cr_r <= '0;
            r_p_cb_g <= '0;
            r_p_cr_g <= '0;
            r_p_cb_b <= '0;
            r_sum_r  <= '0;
            r_sum_g  <= '0;
            r_sum_b  <= '0;
            r_r      <= '0;
            r_g      <= '0;
            r_b      <= '0;
        end else if (pix.ce) begin
            r_y1     <= pix.Y;
            r_cb1    <= w_cb_s;
            r_cr1    <= w_cr_s;

            r_y2     <= YW'(r_y1) << FRAC_BITS;
            r_p_cr_r <= PW'(r_cr1) * C_CR_R;
            r_p_cb_g <= PW'(r_cb1) * C_CB_G;
            r_p_cr_g <= PW'(r_cr1) * C_CR_G;
            r_p_cb_b <= PW'(r_cb1) * C_CB_B;

            r_sum_r  <= w_y_x + SW'(r_p_cr_r) + C_RND;
            r_sum_g  <= w_y_x - SW'(r_p_cb_g) - SW'(r_p_cr_g) + C_RND;
            r_sum_b  <= w_y_x + SW'(r_p_cb_b) + C_RND;

            r_r      <= sat_u8(r_sum_r);
            r_g      <= sat_u8(r_sum_g);
            r_b      <= sat_u8(r_sum_b);
        end
    end

    assign w_strobe_in = '{hsync: pix.in_hsync, vsync: pix.in_vsync, de: pix.in_de};

    sync_delay #(
        .DEPTH (CONV_LATENCY),
        .WIDTH ($bits(strobe_t))
    ) u_sync_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .i_ce  (pix.ce),
        .i_d   (w_strobe_in),
        .o_q   (w_strobe_out)
    );

    assign pix.R         = r_r;
    assign pix.G         = r_g;
    assign pix.B         = r_b;
    assign pix.out_hsync = w_strobe_out.hsync;
    assign pix.out_vsync = w_strobe_out.vsync;
    assign pix.out_de    = w_strobe_out.de;

endmodule
